// File: rtl/rc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : rc_pwm_gen
// Description : Multi-channel RC/servo pulse generator with frame-aligned
//               double-buffered widths and a frame watchdog failsafe.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_pwm_gen #(
    parameter int CHANNELS       = 6,
    parameter int LEN            = 17,
    parameter int CLK_DIV        = 50,
    parameter int FRAME_US       = 20000,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [23:0]         in_data,
    input  logic                in_wr,
    output logic [CHANNELS-1:0] rc_out,
    output logic                frame_stb,
    output logic                timeout
);

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_fc_w  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_fc_w-1:0]  c_fc_last  = c_fc_w'(FRAME_US - 1);
    localparam logic [LEN-1:0]     c_max_w    = LEN'(FRAME_US - 1);

    logic [c_div_w-1:0]  div_q, div_d;
    logic [c_fc_w-1:0]   fc_q, fc_d;
    logic                frame_stb_q;
    logic [CHANNELS-1:0] enable_q;
    logic [CHANNELS-1:0] rc_out_q, rc_out_d;
    logic [LEN-1:0]      shadow_q [CHANNELS];
    logic [LEN-1:0]      active_q [CHANNELS];

    logic                tick;
    logic                boundary;
    logic                trip;
    logic                timeout_q;
    logic [2:0]          idx;
    logic                hdr_ok;
    logic                ch_wr;
    logic                en_wr;
    logic                valid_wr;
    logic [LEN-1:0]      wr_width;
    logic [LEN-1:0]      fc_ext;

    assign tick     = (div_q == c_div_last);
    assign boundary = tick && (fc_q == c_fc_last);

    assign idx      = in_data[19:17];
    assign hdr_ok   = (in_data[23:20] == 4'd0);
    assign en_wr    = in_wr && hdr_ok && (idx == 3'd7);
    assign ch_wr    = in_wr && hdr_ok && (idx != 3'd7) && (32'(idx) < CHANNELS);
    assign valid_wr = en_wr || ch_wr;

    // Clamp keeps at least one low tick in every frame.
    assign wr_width = (in_data[LEN-1:0] > c_max_w) ? c_max_w : in_data[LEN-1:0];
    assign fc_ext   = LEN'(fc_q);

    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        fc_d     = fc_q;
        rc_out_d = '0;
        if (tick) begin
            fc_d = (fc_q == c_fc_last) ? '0 : fc_q + 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            rc_out_d[i] = enable_q[i] && (fc_ext < active_q[i]);
        end
    end

    generate
        if (TIMEOUT_FRAMES > 0) begin : g_wd
            localparam int c_wd_w = $clog2(TIMEOUT_FRAMES + 1);
            localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(TIMEOUT_FRAMES);

            logic [c_wd_w-1:0] wd_q;
            logic [c_wd_w-1:0] wd_inc;

            assign wd_inc = (wd_q == c_wd_max) ? wd_q : wd_q + 1'b1;
            // A write in the boundary cycle wins over the watchdog.
            assign trip   = boundary && !valid_wr && (wd_inc == c_wd_max);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_q      <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    if (valid_wr) begin
                        wd_q      <= '0;
                        timeout_q <= 1'b0;
                    end else if (boundary) begin
                        wd_q <= wd_inc;
                        if (trip) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_wd
            assign trip      = 1'b0;
            assign timeout_q = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            fc_q        <= '0;
            frame_stb_q <= 1'b0;
            enable_q    <= '0;
            rc_out_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            div_q       <= div_d;
            fc_q        <= fc_d;
            frame_stb_q <= boundary;
            rc_out_q    <= rc_out_d;
            if (en_wr) begin
                enable_q <= in_data[CHANNELS-1:0];
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (ch_wr && (idx == 3'(i))) begin
                    shadow_q[i] <= wr_width;
                end
                if (boundary) begin
                    active_q[i] <= trip ? '0 : shadow_q[i];
                end
            end
        end
    end

    assign rc_out    = rc_out_q;
    assign frame_stb = frame_stb_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc_pwm_gen
// Description : Directed self-checking bench for rc_pwm_gen (CLK_DIV=2,
//               FRAME_US=20, TIMEOUT_FRAMES=3 -> 40 clk frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc_pwm_gen;

    localparam int CH = 6;
    localparam int FR = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [23:0]   in_data = '0;
    logic          in_wr = 1'b0;
    logic [CH-1:0] rc_out;
    logic          frame_stb;
    logic          timeout;

    int   tests = 0;
    int   fails = 0;
    int   hi [CH];
    int   stb_hits;
    int   stb_last;
    logic to_s [FR];
    int   n_wait;
    logic any_hi;

    rc_pwm_gen #(
        .CHANNELS       (CH),
        .LEN            (17),
        .CLK_DIV        (2),
        .FRAME_US       (20),
        .TIMEOUT_FRAMES (3)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .rc_out    (rc_out),
        .frame_stb (frame_stb),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "bench time limit exceeded");
    end

    function automatic logic [23:0] cmd(input logic [3:0] h, input logic [2:0] idx,
                                        input logic [16:0] v);
        return {h, idx, v};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [23:0] d);
        in_data = d;
        in_wr   = 1'b1;
        @(negedge clk);
        in_wr   = 1'b0;
    endtask

    // Waits (bounded) for frame_stb, counting negedges and noting any high output.
    task automatic sync_stb();
        n_wait = 0;
        any_hi = 1'b0;
        in_wr  = 1'b0;
        do begin
            @(negedge clk);
            n_wait++;
            if (rc_out != '0) any_hi = 1'b1;
        end while (!frame_stb && n_wait < 200);
    endtask

    // Starts at a negedge where frame_stb is high; covers one full frame.
    task automatic run_frame(input int a1, input logic [23:0] d1,
                             input int a2, input logic [23:0] d2);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        stb_hits = 0;
        stb_last = -1;
        for (int k = 0; k < FR; k++) begin
            if (k == a1) begin
                in_data = d1; in_wr = 1'b1;
            end else if (k == a2) begin
                in_data = d2; in_wr = 1'b1;
            end else begin
                in_wr = 1'b0;
            end
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (rc_out[c]) hi[c]++;
            if (frame_stb) begin
                stb_hits++;
                stb_last = k;
            end
            to_s[k] = timeout;
        end
        in_wr = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1,
                               input int e2, input int erest);
        check({tag, " ch0_high"}, hi[0], e0);
        check({tag, " ch1_high"}, hi[1], e1);
        check({tag, " ch2_high"}, hi[2], e2);
        check({tag, " ch3to5_high"}, hi[3] + hi[4] + hi[5], erest);
        check({tag, " stb_count"}, stb_hits, 1);
        check({tag, " stb_pos"}, stb_last, FR - 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset rc_out", int'(rc_out), 0);
        check("reset frame_stb", int'(frame_stb), 0);
        check("reset timeout", int'(timeout), 0);

        rst_n = 1'b1;
        wr(cmd(4'h0, 3'd7, 17'h3F));
        wr(cmd(4'h0, 3'd0, 17'd5));
        sync_stb();
        check("first_boundary_delay", n_wait + 2, FR);
        check("pre_boundary_low", int'(any_hi), 0);

        run_frame(-1, '0, -1, '0);
        check_frame("A", 10, 0, 0, 0);
        run_frame(5, cmd(4'h0, 3'd2, 17'd7), 10, cmd(4'h0, 3'd2, 17'd3));
        check_frame("B", 10, 0, 0, 0);
        run_frame(5, cmd(4'h0, 3'd1, 17'd100), -1, '0);
        check_frame("C", 10, 0, 6, 0);
        run_frame(5, cmd(4'h0, 3'd1, 17'd0), FR - 1, cmd(4'h0, 3'd0, 17'd8));
        check_frame("D", 10, 38, 6, 0);
        run_frame(-1, '0, -1, '0);
        check_frame("E", 10, 0, 6, 0);
        run_frame(-1, '0, -1, '0);
        check_frame("F", 16, 0, 6, 0);
        check("F end timeout", int'(timeout), 0);
        run_frame(-1, '0, -1, '0);
        check_frame("G", 16, 0, 6, 0);
        check("G end timeout", int'(timeout), 1);
        run_frame(-1, '0, -1, '0);
        check_frame("H", 0, 0, 0, 0);
        check("H end timeout", int'(timeout), 1);

        run_frame(5, cmd(4'h0, 3'd0, 17'd4), -1, '0);
        check_frame("I", 0, 0, 0, 0);
        check("I timeout before write", int'(to_s[4]), 1);
        check("I timeout after write", int'(to_s[5]), 0);

        run_frame(5, cmd(4'h0, 3'd6, 17'd9), 10, cmd(4'h1, 3'd0, 17'd2));
        check_frame("J", 8, 0, 6, 0);
        check("J end timeout", int'(timeout), 0);
        run_frame(5, cmd(4'h0, 3'd6, 17'd9), 10, cmd(4'h1, 3'd0, 17'd2));
        check_frame("K", 8, 0, 6, 0);
        check("K end timeout", int'(timeout), 1);
        run_frame(5, cmd(4'h0, 3'd7, 17'h01), -1, '0);
        check_frame("L", 0, 0, 0, 0);
        check("L end timeout", int'(timeout), 0);

        repeat (3) @(negedge clk);
        check("M only ch0 high", int'(rc_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset rc_out", int'(rc_out), 0);
        check("async reset frame_stb", int'(frame_stb), 0);
        check("async reset timeout", int'(timeout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync_stb();
        check("post_reset boundary_delay", n_wait, FR);
        check("post_reset low", int'(any_hi), 0);
        run_frame(-1, '0, -1, '0);
        check_frame("N", 0, 0, 0, 0);
        check("N end timeout", int'(timeout), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
